// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding and widths.
package div_pkg;

  localparam int unsigned DIV_W  = 8;
  localparam int unsigned DIVD_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract the divisor.
module div_step
  import div_pkg::*;
#(
  parameter int unsigned W = DIV_W
) (
  input  logic [W:0]   pr_i,
  input  logic         bit_i,
  input  logic [W-1:0] divisor_i,
  output logic [W:0]   pr_o,
  output logic         qbit_o
);

  logic [W:0] shifted;
  logic [W:0] addend;
  logic [W:0] diff;
  logic       carry;

  assign shifted = {pr_i[W-1:0], bit_i};
  assign addend  = ~{1'b0, divisor_i};

  // Carry-out of shifted + ~divisor + 1 is the "no borrow" indication.
  assign {carry, diff} = {1'b0, shifted} + {1'b0, addend} + {{(W + 1){1'b0}}, 1'b1};

  // A set bit shifted out of pr means the trial value exceeds any divisor.
  assign qbit_o = carry | pr_i[W];
  assign pr_o   = qbit_o ? diff : shifted;

endmodule

// File: rtl/seq_div_16_by_8.sv
// Iterative 2W-by-W unsigned divider, one quotient bit per cycle, valid/ready on both sides.
module seq_div_16_by_8
  import div_pkg::*;
#(
  parameter int unsigned W = DIV_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*W-1:0] dividend,
  input  logic [W-1:0]   divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   quotient,
  output logic [W-1:0]   remainder,
  output logic           div_zero,
  output logic           overflow
);

  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

  div_state_e     state_q;
  logic [CW-1:0]  cnt_q;
  logic [W:0]     pr_q;
  logic [W-1:0]   low_q;
  logic [W-1:0]   q_q;
  logic [W-1:0]   dvs_q;
  logic           dz_q;
  logic           ov_q;
  logic           in_ready_q;
  logic           out_valid_q;
  logic [W-1:0]   quo_q;
  logic [W-1:0]   rem_q;
  logic           dzo_q;
  logic           ovo_q;

  logic [W:0]     pr_d;
  logic           qbit_d;

  div_step #(
    .W(W)
  ) u_step (
    .pr_i      (pr_q),
    .bit_i     (low_q[W-1]),
    .divisor_i (dvs_q),
    .pr_o      (pr_d),
    .qbit_o    (qbit_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pr_q        <= '0;
      low_q       <= '0;
      q_q         <= '0;
      dvs_q       <= '0;
      dz_q        <= 1'b0;
      ov_q        <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      quo_q       <= '0;
      rem_q       <= '0;
      dzo_q       <= 1'b0;
      ovo_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            dvs_q      <= divisor;
            low_q      <= dividend[W-1:0];
            cnt_q      <= CW'(W - 1);
            in_ready_q <= 1'b0;
            dzo_q      <= 1'b0;
            ovo_q      <= 1'b0;
            // Error results are preloaded into q/pr so DONE publishes every case the same way.
            if (divisor == '0) begin
              dz_q    <= 1'b1;
              ov_q    <= 1'b0;
              q_q     <= '1;
              pr_q    <= {1'b0, dividend[W-1:0]};
              state_q <= DONE;
            end else if (dividend[2*W-1:W] >= divisor) begin
              dz_q    <= 1'b0;
              ov_q    <= 1'b1;
              q_q     <= '1;
              pr_q    <= {1'b0, {W{1'b1}}};
              state_q <= DONE;
            end else begin
              dz_q    <= 1'b0;
              ov_q    <= 1'b0;
              q_q     <= '0;
              pr_q    <= {1'b0, dividend[2*W-1:W]};
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          pr_q  <= pr_d;
          low_q <= {low_q[W-2:0], 1'b0};
          q_q   <= {q_q[W-2:0], qbit_d};
          if (cnt_q == '0) begin
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        DONE: begin
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            quo_q       <= q_q;
            rem_q       <= pr_q[W-1:0];
            dzo_q       <= dz_q;
            ovo_q       <= ov_q;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign div_zero  = dzo_q;
  assign overflow  = ovo_q;

endmodule
